// File: rtl/pool_arb.sv
// Two-channel frame-granular arbiter sharing a single maxpool unit.
// Optional per-channel frame statistics are enabled with the POOL_ARB_STAT_EN macro.
module pool_arb #(
    parameter int reludata_num = 6,
    parameter int SAMPLE_GAP   = 3
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ch0_valid,
    input  logic [21:0] ch0_data,
    input  logic        ch1_valid,
    input  logic [21:0] ch1_data,
    output logic        ch0_ready,
    output logic        ch1_ready,
    output logic        relu_valid,
    output logic [21:0] relu_data,
    input  logic        maxpool_valid,
    input  logic [21:0] maxpool_data,
    output logic        pool_valid,
    output logic [21:0] pool_data,
    output logic        pool_ch,
    output logic        frame_done,
    output logic        busy
`ifdef POOL_ARB_STAT_EN
    ,
    output logic [15:0] stat_frames0,
    output logic [15:0] stat_frames1
`endif
);

    localparam int FRAME_IN  = reludata_num * reludata_num;
    localparam int FRAME_OUT = (reludata_num / 2) * (reludata_num / 2);
    localparam int IN_W      = $clog2(FRAME_IN + 1);
    localparam int OUT_W     = $clog2(FRAME_OUT + 1);
    localparam int GAP_W     = (SAMPLE_GAP > 0) ? $clog2(SAMPLE_GAP + 1) : 1;

    localparam logic [IN_W-1:0]  IN_FULL  = IN_W'(FRAME_IN);
    localparam logic [IN_W-1:0]  IN_LAST  = IN_W'(FRAME_IN - 1);
    localparam logic [OUT_W-1:0] OUT_LAST = OUT_W'(FRAME_OUT - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(SAMPLE_GAP);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_last_grant;
    logic               r_owner;
    logic [IN_W-1:0]    r_in_cnt;
    logic [OUT_W-1:0]   r_res_cnt;
    logic [GAP_W-1:0]   r_gap;
    logic               r_relu_valid;
    logic [21:0]        r_relu_data;
    logic               r_pool_valid;
    logic [21:0]        r_pool_data;
    logic               r_pool_ch;
    logic               r_frame_done;

    logic               w_can_take;
    logic               w_accept;
    logic [21:0]        w_acc_data;
    logic               w_result;
    logic               w_in_last;
    logic               w_frame_end;

    assign w_can_take  = (r_gap == '0) && (r_in_cnt < IN_FULL);
    assign ch0_ready   = (r_state == GRANT0) && w_can_take;
    assign ch1_ready   = (r_state == GRANT1) && w_can_take;
    assign w_accept    = (ch0_valid && ch0_ready) || (ch1_valid && ch1_ready);
    assign w_acc_data  = (r_state == GRANT1) ? ch1_data : ch0_data;
    // Results are only meaningful while a frame is owned; IDLE pulses are dropped.
    assign w_result    = maxpool_valid && (r_state != IDLE);
    assign w_in_last   = w_accept && (r_in_cnt == IN_LAST);
    assign w_frame_end = w_result && (r_res_cnt == OUT_LAST);

    assign relu_valid  = r_relu_valid;
    assign relu_data   = r_relu_data;
    assign pool_valid  = r_pool_valid;
    assign pool_data   = r_pool_data;
    assign pool_ch     = r_pool_ch;
    assign frame_done  = r_frame_done;
    assign busy        = (r_state != IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_in_cnt     <= '0;
            r_res_cnt    <= '0;
            r_gap        <= '0;
            r_relu_valid <= 1'b0;
            r_relu_data  <= '0;
            r_pool_valid <= 1'b0;
            r_pool_data  <= '0;
            r_pool_ch    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_relu_valid <= w_accept;
            r_relu_data  <= w_accept ? w_acc_data : '0;
            r_pool_valid <= w_result;
            r_pool_data  <= w_result ? maxpool_data : '0;
            r_pool_ch    <= w_result ? r_owner : 1'b0;
            r_frame_done <= w_frame_end;

            if (w_accept) begin
                r_gap <= GAP_LOAD;
            end else if (r_gap != '0) begin
                r_gap <= r_gap - GAP_W'(1);
            end

            if (w_in_last) begin
                r_in_cnt <= '0;
            end else if (w_accept) begin
                r_in_cnt <= r_in_cnt + IN_W'(1);
            end

            if (w_result) begin
                r_res_cnt <= r_res_cnt + OUT_W'(1);
            end

            case (r_state)
                IDLE: begin
                    if (ch0_valid && (!ch1_valid || r_last_grant)) begin
                        r_state <= GRANT0;
                        r_owner <= 1'b0;
                    end else if (ch1_valid) begin
                        r_state <= GRANT1;
                        r_owner <= 1'b1;
                    end
                end
                GRANT0, GRANT1: begin
                    if (w_in_last) begin
                        r_state      <= DRAIN;
                        r_last_grant <= r_owner;
                    end
                end
                DRAIN: begin
                end
                default: r_state <= IDLE;
            endcase

            // Frame end wins over everything: counters restart and the spacing window is cleared.
            if (w_frame_end) begin
                r_state   <= IDLE;
                r_in_cnt  <= '0;
                r_res_cnt <= '0;
                r_gap     <= '0;
            end
        end
    end

`ifdef POOL_ARB_STAT_EN
    logic [15:0] r_stat0;
    logic [15:0] r_stat1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stat0 <= '0;
            r_stat1 <= '0;
        end else if (w_frame_end) begin
            if (!r_owner && (r_stat0 != 16'hFFFF)) begin
                r_stat0 <= r_stat0 + 16'd1;
            end
            if (r_owner && (r_stat1 != 16'hFFFF)) begin
                r_stat1 <= r_stat1 + 16'd1;
            end
        end
    end

    assign stat_frames0 = r_stat0;
    assign stat_frames1 = r_stat1;
`endif

endmodule

// File: tb/tb_pool_arb.sv
// Self-checking bench for pool_arb: a transaction-level model (grant owner, accept
// timestamps, frame counts) predicts every cycle of the DUT under directed and random stimulus.
`timescale 1ns/1ps
module tb_pool_arb;

    localparam int N   = 6;
    localparam int GAP = 3;
    localparam int N2  = N * N;
    localparam int M   = (N / 2) * (N / 2);

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        ch0_valid = 1'b0;
    logic [21:0] ch0_data = '0;
    logic        ch1_valid = 1'b0;
    logic [21:0] ch1_data = '0;
    logic        maxpool_valid = 1'b0;
    logic [21:0] maxpool_data = '0;
    logic        ch0_ready, ch1_ready, relu_valid, pool_valid, pool_ch, frame_done, busy;
    logic [21:0] relu_data, pool_data;
`ifdef POOL_ARB_STAT_EN
    logic [15:0] stat_frames0, stat_frames1;
`endif

    always #5 clk = ~clk;

    pool_arb #(.reludata_num(N), .SAMPLE_GAP(GAP)) dut (
        .clk(clk), .rstn(rstn),
        .ch0_valid(ch0_valid), .ch0_data(ch0_data),
        .ch1_valid(ch1_valid), .ch1_data(ch1_data),
        .ch0_ready(ch0_ready), .ch1_ready(ch1_ready),
        .relu_valid(relu_valid), .relu_data(relu_data),
        .maxpool_valid(maxpool_valid), .maxpool_data(maxpool_data),
        .pool_valid(pool_valid), .pool_data(pool_data), .pool_ch(pool_ch),
        .frame_done(frame_done), .busy(busy)
`ifdef POOL_ARB_STAT_EN
        , .stat_frames0(stat_frames0), .stat_frames1(stat_frames1)
`endif
    );

    logic [50:0] dut_outs;
    assign dut_outs = {ch0_ready, ch1_ready, relu_valid, relu_data, pool_valid,
                       pool_data, pool_ch, frame_done, busy};

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: who owns the maxpool, how many samples/results this frame,
    // and the cycle of the last accepted sample.
    int  m_owner, m_last, m_acc, m_res, m_last_acc, cyc;
    bit  m_drain;
    int  e_stat0, e_stat1;

    bit          e_rdy0, e_rdy1, e_busy, e_relu_valid, e_pool_valid, e_pool_ch, e_frame_done, e_busy_post;
    logic [21:0] e_relu_data, e_pool_data;
    logic        a_rdy0, a_rdy1, a_busy, a_relu_valid, a_pool_valid, a_pool_ch, a_frame_done, a_busy_post;
    logic [21:0] a_relu_data, a_pool_data;

    task automatic reset_model();
        m_owner = -1; m_drain = 0; m_last = 1; m_acc = 0; m_res = 0;
        m_last_acc = -1000; e_stat0 = 0; e_stat1 = 0;
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        ch0_valid = 1'b0; ch1_valid = 1'b0; maxpool_valid = 1'b0;
        reset_model();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    // One clock: predict from the current inputs, sample combinational outputs before the
    // edge and registered outputs 1ns after it.
    task automatic tick();
        bit acc0, acc1, res, done;
        int own;
        #1;
        own    = m_owner;
        e_busy = (own >= 0);
        e_rdy0 = (own == 0) && !m_drain && (cyc - m_last_acc > GAP) && (m_acc < N2);
        e_rdy1 = (own == 1) && !m_drain && (cyc - m_last_acc > GAP) && (m_acc < N2);
        a_rdy0 = ch0_ready; a_rdy1 = ch1_ready; a_busy = busy;
        acc0 = ch0_valid && e_rdy0;
        acc1 = ch1_valid && e_rdy1;
        e_relu_valid = acc0 || acc1;
        e_relu_data  = acc0 ? ch0_data : (acc1 ? ch1_data : 22'd0);
        res          = maxpool_valid && (own >= 0);
        e_pool_valid = res;
        e_pool_data  = res ? maxpool_data : 22'd0;
        e_pool_ch    = res && (own == 1);
        done         = res && (m_res + 1 == M);
        e_frame_done = done;
        if (acc0 || acc1) begin
            m_acc++;
            m_last_acc = cyc;
            if (m_acc == N2) begin
                m_drain = 1;
                m_last  = own;
            end
        end
        if (res) m_res++;
        if (own < 0) begin
            if (ch0_valid && ch1_valid) m_owner = (m_last == 0) ? 1 : 0;
            else if (ch0_valid)         m_owner = 0;
            else if (ch1_valid)         m_owner = 1;
        end
        if (done) begin
            if (own == 0 && e_stat0 < 65535) e_stat0++;
            if (own == 1 && e_stat1 < 65535) e_stat1++;
            m_owner = -1; m_drain = 0; m_acc = 0; m_res = 0; m_last_acc = -1000;
        end
        e_busy_post = (m_owner >= 0);
        @(posedge clk); #1;
        a_relu_valid = relu_valid; a_relu_data = relu_data;
        a_pool_valid = pool_valid; a_pool_data = pool_data; a_pool_ch = pool_ch;
        a_frame_done = frame_done; a_busy_post = busy;
        cyc++;
    endtask

    // Random traffic; maxpool results are only offered once enough samples exist to produce them.
    task automatic stim_cycle(input int p0, input int p1, input bit idle_mp);
        ch0_valid = ($urandom_range(0, 99) < p0);
        ch1_valid = ($urandom_range(0, 99) < p1);
        ch0_data  = 22'($urandom);
        ch1_data  = 22'($urandom);
        if (m_owner >= 0) maxpool_valid = ((m_res + 1) * N2 <= m_acc * M) && ($urandom_range(0, 1) == 1);
        else              maxpool_valid = idle_mp && ($urandom_range(0, 9) == 0);
        maxpool_data = 22'($urandom);
        tick();
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        n_tests++;
        if (dut_outs !== 51'd0) begin
            n_fail++; $display("FAIL reset_outputs got=%h want=0", dut_outs);
        end
`ifdef POOL_ARB_STAT_EN
        n_tests++;
        if ({stat_frames0, stat_frames1} !== 32'd0) begin
            n_fail++; $display("FAIL reset_stats got=%h want=0", {stat_frames0, stat_frames1});
        end
`endif
        reset_model();
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if ({a_rdy0, a_rdy1, a_busy, a_busy_post, a_relu_valid, a_pool_valid} !== 6'd0) begin
                n_fail++; $display("FAIL reset_idle cyc=%0d got=%b want=000000", cyc,
                                   {a_rdy0, a_rdy1, a_busy, a_busy_post, a_relu_valid, a_pool_valid});
            end
        end
    endtask

    task automatic test_ch0_stream();
        int k = 0;
        int seen = 0;
        ch0_valid = 1'b1; ch1_valid = 1'b0; maxpool_valid = 1'b0;
        for (int c = 0; c < 400 && !m_drain; c++) begin
            ch0_data = 22'(k);
            tick();
            n_tests++;
            if ({a_rdy0, a_rdy1, a_busy} !== {e_rdy0, e_rdy1, e_busy}) begin
                n_fail++; $display("FAIL stream_ready cyc=%0d got=%b want=%b", cyc,
                                   {a_rdy0, a_rdy1, a_busy}, {e_rdy0, e_rdy1, e_busy});
            end
            n_tests++;
            if ({a_relu_valid, a_relu_data} !== {e_relu_valid, e_relu_data}) begin
                n_fail++; $display("FAIL stream_relu cyc=%0d got=%b/%0d want=%b/%0d", cyc,
                                   a_relu_valid, a_relu_data, e_relu_valid, e_relu_data);
            end
            if (a_relu_valid === 1'b1) seen++;
            if (e_relu_valid) k++;
        end
        ch0_valid = 1'b0;
        n_tests++;
        if (seen != N2) begin
            n_fail++; $display("FAIL stream_count got=%0d want=%0d", seen, N2);
        end
        tick();
        n_tests++;
        if ({a_rdy0, a_rdy1, a_busy, a_busy_post} !== 4'b0011) begin
            n_fail++; $display("FAIL stream_drain got=%b want=0011", {a_rdy0, a_rdy1, a_busy, a_busy_post});
        end
    endtask

    task automatic test_pool_results();
        int npool = 0;
        for (int i = 0; i < M; i++) begin
            maxpool_valid = 1'b1;
            maxpool_data  = 22'($urandom);
            tick();
            maxpool_valid = 1'b0;
            n_tests++;
            if ({a_pool_valid, a_pool_data, a_pool_ch, a_frame_done, a_busy_post} !==
                {e_pool_valid, e_pool_data, e_pool_ch, e_frame_done, e_busy_post}) begin
                n_fail++; $display("FAIL pool_result idx=%0d got=%b/%h/%b/%b/%b want=%b/%h/%b/%b/%b", i,
                                   a_pool_valid, a_pool_data, a_pool_ch, a_frame_done, a_busy_post,
                                   e_pool_valid, e_pool_data, e_pool_ch, e_frame_done, e_busy_post);
            end
            if (a_pool_valid === 1'b1) npool++;
            repeat ($urandom_range(0, 2)) tick();
        end
        n_tests++;
        if (npool != M) begin
            n_fail++; $display("FAIL pool_count got=%0d want=%0d", npool, M);
        end
    endtask

    task automatic test_round_robin();
        int frames = 0;
        bit got = 0;
        int owners[3] = '{-1, -1, -1};
        apply_reset();
        for (int c = 0; c < 3000 && frames < 3; c++) begin
            stim_cycle(100, 100, 0);
            n_tests++;
            if ({a_rdy0, a_rdy1, a_busy, a_relu_valid, a_relu_data, a_pool_valid, a_pool_ch, a_frame_done, a_busy_post} !==
                {e_rdy0, e_rdy1, e_busy, e_relu_valid, e_relu_data, e_pool_valid, e_pool_ch, e_frame_done, e_busy_post}) begin
                n_fail++; $display("FAIL rr_cycle cyc=%0d rdy=%b%b relu=%b/%h pool=%b/%b done=%b want rdy=%b%b relu=%b/%h pool=%b/%b done=%b",
                                   cyc, a_rdy0, a_rdy1, a_relu_valid, a_relu_data, a_pool_valid, a_pool_ch, a_frame_done,
                                   e_rdy0, e_rdy1, e_relu_valid, e_relu_data, e_pool_valid, e_pool_ch, e_frame_done);
            end
            if (!got && (a_rdy0 === 1'b1 || a_rdy1 === 1'b1)) begin
                owners[frames] = (a_rdy1 === 1'b1) ? 1 : 0;
                got = 1;
            end
            if (a_frame_done === 1'b1) begin
                frames++;
                got = 0;
            end
        end
        n_tests++;
        if (frames != 3) begin
            n_fail++; $display("FAIL rr_frames got=%0d want=3", frames);
        end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (owners[i] != (i % 2)) begin
                n_fail++; $display("FAIL rr_owner frame=%0d got=%0d want=%0d", i, owners[i], i % 2);
            end
        end
        ch0_valid = 1'b0; ch1_valid = 1'b0; maxpool_valid = 1'b0;
    endtask

    task automatic test_mid_reset();
        int k = 0;
        int seen = 0;
        apply_reset();
        ch0_valid = 1'b1;
        for (int c = 0; c < 400 && m_acc < 20; c++) begin
            ch0_data = 22'(k);
            tick();
            if (e_relu_valid) k++;
        end
        rstn = 1'b0;
        #1;
        n_tests++;
        if (dut_outs !== 51'd0) begin
            n_fail++; $display("FAIL midrst_outputs got=%h want=0", dut_outs);
        end
        reset_model();
        @(posedge clk); #1;
        rstn = 1'b1;
        k = 0;
        for (int c = 0; c < 400 && !m_drain; c++) begin
            ch0_data = 22'(k);
            tick();
            n_tests++;
            if ({a_rdy0, a_rdy1, a_busy, a_relu_valid, a_relu_data, a_busy_post, a_frame_done} !==
                {e_rdy0, e_rdy1, e_busy, e_relu_valid, e_relu_data, e_busy_post, e_frame_done}) begin
                n_fail++; $display("FAIL midrst_frame cyc=%0d rdy=%b relu=%b/%0d want rdy=%b relu=%b/%0d", cyc,
                                   a_rdy0, a_relu_valid, a_relu_data, e_rdy0, e_relu_valid, e_relu_data);
            end
            if (a_relu_valid === 1'b1) seen++;
            if (e_relu_valid) k++;
        end
        ch0_valid = 1'b0;
        n_tests++;
        if (seen != N2) begin
            n_fail++; $display("FAIL midrst_count got=%0d want=%0d", seen, N2);
        end
    endtask

    task automatic test_idle_maxpool();
        int npool = 0;
        int ndone = 0;
        apply_reset();
        maxpool_valid = 1'b1;
        maxpool_data  = 22'h155;
        tick();
        maxpool_valid = 1'b0;
        n_tests++;
        if ({a_pool_valid, a_pool_data, a_frame_done, a_busy_post} !== 25'd0) begin
            n_fail++; $display("FAIL idle_mp got=%b/%h/%b/%b want=0/0/0/0", a_pool_valid, a_pool_data, a_frame_done, a_busy_post);
        end
        for (int c = 0; c < 2000 && ndone < 1; c++) begin
            stim_cycle(0, 100, 0);
            n_tests++;
            if ({a_rdy1, a_pool_valid, a_pool_data, a_pool_ch, a_frame_done} !==
                {e_rdy1, e_pool_valid, e_pool_data, e_pool_ch, e_frame_done}) begin
                n_fail++; $display("FAIL idle_frame cyc=%0d got=%b/%b/%h/%b/%b want=%b/%b/%h/%b/%b", cyc,
                                   a_rdy1, a_pool_valid, a_pool_data, a_pool_ch, a_frame_done,
                                   e_rdy1, e_pool_valid, e_pool_data, e_pool_ch, e_frame_done);
            end
            if (a_pool_valid === 1'b1) npool++;
            if (a_frame_done === 1'b1) ndone++;
        end
        ch1_valid = 1'b0; maxpool_valid = 1'b0;
        n_tests++;
        if (npool != M || ndone != 1) begin
            n_fail++; $display("FAIL idle_results got=%0d/%0d want=%0d/1", npool, ndone, M);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 1500; c++) begin
            stim_cycle(60, 60, 1);
            n_tests++;
            if ({a_rdy0, a_rdy1, a_busy, a_relu_valid, a_relu_data, a_pool_valid, a_pool_data, a_pool_ch, a_frame_done, a_busy_post} !==
                {e_rdy0, e_rdy1, e_busy, e_relu_valid, e_relu_data, e_pool_valid, e_pool_data, e_pool_ch, e_frame_done, e_busy_post}) begin
                n_fail++; $display("FAIL random cyc=%0d rdy=%b%b busy=%b relu=%b/%h pool=%b/%h/%b done=%b want rdy=%b%b busy=%b relu=%b/%h pool=%b/%h/%b done=%b",
                                   cyc, a_rdy0, a_rdy1, a_busy, a_relu_valid, a_relu_data, a_pool_valid, a_pool_data, a_pool_ch, a_frame_done,
                                   e_rdy0, e_rdy1, e_busy, e_relu_valid, e_relu_data, e_pool_valid, e_pool_data, e_pool_ch, e_frame_done);
            end
        end
        ch0_valid = 1'b0; ch1_valid = 1'b0; maxpool_valid = 1'b0;
    endtask

`ifdef POOL_ARB_STAT_EN
    task automatic test_stats();
        int ndone = 0;
        apply_reset();
        for (int c = 0; c < 3000 && ndone < 3; c++) begin
            stim_cycle(0, 100, 0);
            if (a_frame_done === 1'b1) ndone++;
        end
        ch1_valid = 1'b0; maxpool_valid = 1'b0;
        tick();
        n_tests++;
        if ({stat_frames0, stat_frames1} !== {16'(e_stat0), 16'(e_stat1)} || stat_frames1 !== 16'd3) begin
            n_fail++; $display("FAIL stats got=%0d/%0d want=0/3", stat_frames0, stat_frames1);
        end
    endtask
`endif

    initial begin
        cyc = 0;
        reset_model();
        test_reset();
        test_ch0_stream();
        test_pool_results();
        test_round_robin();
        test_mid_reset();
        test_idle_maxpool();
        test_random();
`ifdef POOL_ARB_STAT_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pool_arb.md
POOL_ARB -- requirements
Module: pool_arb

Interface
REQ-001 SHALL have parameter reludata_num, default 6, meaning frame row/column length in samples (even, ≥2).
REQ-002 SHALL have parameter SAMPLE_GAP, default 3, meaning idle cycles forced between accepted samples.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports ch0_valid / ch1_valid  input  1  channel sample offered.
REQ-006 SHALL have ports ch0_data / ch1_data  input  22  channel ReLU sample.
REQ-007 SHALL have ports ch0_ready / ch1_ready  output  1  channel sample accepted this cycle if valid.
REQ-008 SHALL have ports relu_valid  output  1 and relu_data  output  22, driving the shared maxpool input.
REQ-009 SHALL have ports maxpool_valid  input  1 and maxpool_data  input  22, the shared maxpool result.
REQ-010 SHALL have ports pool_valid  output  1, pool_data  output  22 and pool_ch  output  1, the routed result and its owning channel.
REQ-011 SHALL have ports frame_done  output  1 (one-cycle pulse) and busy  output  1.

Function
REQ-012 SHALL share one maxpool between two channels at frame granularity; a grant lasts exactly reludata_num² accepted samples.
REQ-013 SHALL implement FSM IDLE, GRANT0, GRANT1, DRAIN; busy = (state != IDLE).
REQ-014 IDLE: one chX_valid -> GRANTx; both -> grant channel != last_grant (round robin); none -> stay.
REQ-015 chX_ready SHALL be 1 only in GRANTx, gap counter = 0, and in-count < reludata_num²; non-granted ready = 0.
REQ-016 Accept (valid & ready) at cycle t SHALL produce relu_valid = 1, relu_data = sample at t+1; otherwise relu_valid = 0, relu_data = 0.
REQ-017 After each accept, ready SHALL stay 0 for exactly SAMPLE_GAP cycles (SAMPLE_GAP = 0: back-to-back accepts allowed).
REQ-018 On accept number reludata_num², FSM SHALL enter DRAIN next cycle; last_grant updated to that channel.
REQ-019 maxpool_valid at t SHALL produce pool_valid = 1, pool_data = maxpool_data, pool_ch = owner at t+1, in GRANTx and DRAIN.
REQ-020 Result counter SHALL count to (reludata_num/2)²; the final pool_valid SHALL coincide with frame_done = 1, and FSM SHALL return to IDLE that same cycle.
REQ-021 maxpool_valid in IDLE SHALL be ignored: no pool_valid, no count change.
REQ-022 Grant SHALL not be abortable; requests of other channel wait; counters wrap to 0 at frame end.

Reset
REQ-023 rstn low SHALL asynchronously force state IDLE, all counters 0, last_grant = 1 (ch0 wins first tie), and all outputs 0.
REQ-024 Reset mid-frame SHALL discard the partial frame; no frame_done issued.

Configuration
REQ-025 Macro POOL_ARB_STAT_EN defined: SHALL add outputs stat_frames0 / stat_frames1 (16 bits), incremented on frame_done for owner, saturating at 0xFFFF, reset 0.
REQ-026 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Verification (reludata_num = 6, SAMPLE_GAP = 3)
REQ-027 ch0 alone streams 36 samples 0..35 -> ch0_ready once per 4 cycles, relu_data 0..35 one cycle after each accept, ch1_ready always 0.
REQ-028 Model maxpool returns 9 results -> pool_valid ×9 with pool_ch = 0, frame_done coincident with 9th, busy drops same cycle.
REQ-029 ch0 and ch1 both valid from reset -> ch0 granted first, ch1 granted immediately after ch0 frame_done, then ch0 again.
REQ-030 rstn low after 20 ch0 accepts -> all outputs 0, IDLE; next frame needs full 36 accepts before DRAIN.
REQ-031 maxpool_valid pulsed in IDLE with data 0x155 -> no pool_valid, next frame still yields exactly 9 results.
REQ-032 POOL_ARB_STAT_EN defined, 3 ch1 frames -> stat_frames1 = 3, stat_frames0 = 0.
